// File: rtl/st7789_cell_redraw_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// st7789_cell_redraw_sched_if : scheduler <-> board / SPI sender / vmem bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface st7789_cell_redraw_sched_if #(
  parameter int N  = 42,
  parameter int IW = 6
);
  logic          i_init_done;
  logic [N-1:0]  i_dirty_set;
  logic          i_full_req;
  logic          o_spi_en;
  logic [8:0]    o_spi_data;
  logic          i_spi_busy;
  logic [15:0]   o_raddr;
  logic [15:0]   i_rdata;
  logic          o_busy;
  logic [IW-1:0] o_cur_cell;
  logic          o_cell_done;
  logic [N-1:0]  o_pending;

  modport master (
    input  i_init_done, i_dirty_set, i_full_req, i_spi_busy, i_rdata,
    output o_spi_en, o_spi_data, o_raddr, o_busy, o_cur_cell, o_cell_done, o_pending
  );

  modport slave (
    output i_init_done, i_dirty_set, i_full_req, i_spi_busy, i_rdata,
    input  o_spi_en, o_spi_data, o_raddr, o_busy, o_cur_cell, o_cell_done, o_pending
  );
endinterface
`default_nettype wire

// File: rtl/st7789_cell_redraw_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// st7789_cell_redraw_sched : queues dirty board cells and redraws each one
// through a CASET/RASET/RAMWR window followed by its pixels.   Rev 1.0
// ---------------------------------------------------------------------------
module st7789_cell_redraw_sched #(
  parameter int COLS   = 7,
  parameter int ROWS   = 6,
  parameter int CELL   = 32,
  parameter int X0     = 8,
  parameter int Y0     = 48,
  parameter int RD_LAT = 2
) (
  input  wire logic w_clk,
  input  wire logic w_rst,
  st7789_cell_redraw_sched_if.master bus
);
  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int WW = $clog2(RD_LAT + 2);
  localparam logic [WW-1:0] LAT_CNT = WW'(RD_LAT);

  if ((X0 + COLS * CELL > 240) || (Y0 + ROWS * CELL > 240)) begin : g_geom_check
    $error("board geometry exceeds the 240x240 panel");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PICK   = 3'd1,
    S_CMD    = 3'd2,
    S_FETCH  = 3'd3,
    S_PIX_HI = 3'd4,
    S_PIX_LO = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  pending, clr;
  logic [IW-1:0] pick_idx, cur_cell;
  logic [31:0]   col_w, row_w;
  logic [7:0]    xs_n, ys_n;
  logic [7:0]    xs, xe, ys, ye, px, py;
  logic [3:0]    cmd_idx;
  logic [WW-1:0] wcnt;
  logic [15:0]   pix;
  logic          spi_en, busy, cell_done;
  logic [8:0]    spi_data, cmd_byte, send_byte;
  logic          can_send, send, last_px;

  // lowest set index wins
  always_comb begin
    pick_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) pick_idx = IW'(i);
    end
  end

  always_comb begin
    col_w = 32'(pick_idx) / ROWS;
    row_w = 32'(pick_idx) % ROWS;
    xs_n  = 8'(X0 + col_w * CELL);
    ys_n  = 8'(Y0 + row_w * CELL);
    clr   = '0;
    if (state == S_PICK) clr[pick_idx] = 1'b1;
  end

  always_comb begin
    case (cmd_idx)
      4'd0:    cmd_byte = 9'h02A;
      4'd1:    cmd_byte = 9'h100;
      4'd2:    cmd_byte = {1'b1, xs};
      4'd3:    cmd_byte = 9'h100;
      4'd4:    cmd_byte = {1'b1, xe};
      4'd5:    cmd_byte = 9'h02B;
      4'd6:    cmd_byte = 9'h100;
      4'd7:    cmd_byte = {1'b1, ys};
      4'd8:    cmd_byte = 9'h100;
      4'd9:    cmd_byte = {1'b1, ye};
      default: cmd_byte = 9'h02C;
    endcase
  end

  // the sender's busy already covers its own strobe cycle
  assign can_send = !bus.i_spi_busy && !spi_en;
  assign last_px  = (px == xe) && (py == ye);

  always_comb begin
    state_n   = state;
    send      = 1'b0;
    send_byte = spi_data;
    case (state)
      S_IDLE:   if (bus.i_init_done && (|pending)) state_n = S_PICK;
      S_PICK:   state_n = S_CMD;
      S_CMD: begin
        if (can_send) begin
          send      = 1'b1;
          send_byte = cmd_byte;
          if (cmd_idx == 4'd10) state_n = S_FETCH;
        end
      end
      S_FETCH:  if (wcnt == LAT_CNT) state_n = S_PIX_HI;
      S_PIX_HI: begin
        if (can_send) begin
          send      = 1'b1;
          send_byte = {1'b1, pix[15:8]};
          state_n   = S_PIX_LO;
        end
      end
      S_PIX_LO: begin
        if (can_send) begin
          send      = 1'b1;
          send_byte = {1'b1, pix[7:0]};
          state_n   = last_px ? S_IDLE : S_FETCH;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pending   <= '0;
      spi_en    <= 1'b0;
      spi_data  <= '0;
      busy      <= 1'b0;
      cell_done <= 1'b0;
      cur_cell  <= '0;
      xs        <= '0;
      xe        <= '0;
      ys        <= '0;
      ye        <= '0;
      px        <= '0;
      py        <= '0;
      cmd_idx   <= '0;
      wcnt      <= '0;
      pix       <= '0;
    end else begin
      // a strobe landing on the cleared bit wins, re-queuing the cell
      pending   <= (pending & ~clr) | bus.i_dirty_set | {N{bus.i_full_req}};
      spi_en    <= send;
      cell_done <= 1'b0;
      if (send) spi_data <= send_byte;
      case (state)
        S_IDLE: if (state_n == S_PICK) busy <= 1'b1;
        S_PICK: begin
          cur_cell <= pick_idx;
          xs       <= xs_n;
          xe       <= xs_n + 8'(CELL - 1);
          ys       <= ys_n;
          ye       <= ys_n + 8'(CELL - 1);
          cmd_idx  <= '0;
        end
        S_CMD: begin
          if (send) begin
            cmd_idx <= cmd_idx + 4'd1;
            if (cmd_idx == 4'd10) begin
              px   <= xs;
              py   <= ys;
              wcnt <= '0;
            end
          end
        end
        S_FETCH: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == LAT_CNT) pix <= bus.i_rdata;
        end
        S_PIX_LO: begin
          if (send) begin
            wcnt <= '0;
            if (last_px) begin
              cell_done <= 1'b1;
              busy      <= 1'b0;
            end else if (px == xe) begin
              px <= xs;
              py <= py + 8'd1;
            end else begin
              px <= px + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_spi_en    = spi_en;
  assign bus.o_spi_data  = spi_data;
  assign bus.o_raddr     = {py, px};
  assign bus.o_busy      = busy;
  assign bus.o_cur_cell  = cur_cell;
  assign bus.o_cell_done = cell_done;
  assign bus.o_pending   = pending;
endmodule
`default_nettype wire

// File: tb/tb_st7789_cell_redraw_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_st7789_cell_redraw_sched : scoreboard bench for the cell redraw scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_st7789_cell_redraw_sched;
  localparam int COLS = 7, ROWS = 6, CELL = 32, X0 = 8, Y0 = 48, RD_LAT = 2;
  localparam int N = COLS * ROWS, IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  st7789_cell_redraw_sched_if #(.N(N), .IW(IW)) bus ();
  st7789_cell_redraw_sched #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .X0(X0), .Y0(Y0), .RD_LAT(RD_LAT)
  ) dut (
    .w_clk(clk),
    .w_rst(rst),
    .bus  (bus)
  );

  int errors = 0, checks = 0;
  int byte_total = 0, done_cnt = 0;
  logic [15:0] done_raddr = '0;
  logic [8:0]  exp_q[$];
  int          exp_cell_q[$];
  logic [8:0]  mon_b;
  int          mon_c;

  // vmem: RD_LAT-deep pipeline, content is a fixed scramble of the address
  logic [15:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bus.o_raddr ^ 16'hA5C3;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.i_rdata = rd_pipe[RD_LAT-1];

  // SPI sender: busy during the strobe and busy_len cycles after it
  int   busy_len = 0;
  int   bcnt = 0;
  logic prev_busy = 1'b0;
  assign bus.i_spi_busy = bus.o_spi_en | (bcnt != 0);
  always @(posedge clk) begin
    prev_busy <= bus.i_spi_busy;
    if (bus.o_spi_en) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  function automatic logic [7:0] cell_x(input int c);
    return 8'(X0 + (c / ROWS) * CELL);
  endfunction
  function automatic logic [7:0] cell_y(input int c);
    return 8'(Y0 + (c % ROWS) * CELL);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_spi_en) begin
      byte_total++;
      checks++;
      assert (prev_busy === 1'b0) else begin
        errors++;
        $error("FAIL en_in_busy observed prev_busy=%0b expected 0", prev_busy);
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_byte observed %h expected no byte", bus.o_spi_data);
      end
      if (exp_q.size() != 0) begin
        mon_b = exp_q.pop_front();
        checks++;
        assert (bus.o_spi_data === mon_b) else begin
          errors++;
          $error("FAIL byte%0d observed %h expected %h", byte_total, bus.o_spi_data, mon_b);
        end
      end
    end
    if (!rst && bus.o_cell_done) begin
      done_cnt++;
      done_raddr = bus.o_raddr;
      mon_c = (exp_cell_q.size() != 0) ? exp_cell_q.pop_front() : -1;
      checks++;
      assert (int'(bus.o_cur_cell) === mon_c) else begin
        errors++;
        $error("FAIL done_cell observed %0d expected %0d", bus.o_cur_cell, mon_c);
      end
      checks++;
      assert (bus.o_raddr === {cell_y(mon_c) + 8'(CELL-1), cell_x(mon_c) + 8'(CELL-1)}) else begin
        errors++;
        $error("FAIL last_raddr observed %h expected cell %0d corner", bus.o_raddr, mon_c);
      end
    end
  end

  task automatic push_cell(input int c);
    logic [7:0] xs, ys, xe, ye;
    logic [15:0] p;
    xs = cell_x(c); ys = cell_y(c); xe = xs + 8'(CELL-1); ye = ys + 8'(CELL-1);
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back({1'b1, xs});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, xe});
    exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back({1'b1, ys});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, ye});
    exp_q.push_back(9'h02C);
    for (int y = int'(ys); y <= int'(ye); y++) begin
      for (int x = int'(xs); x <= int'(xe); x++) begin
        p = {8'(y), 8'(x)} ^ 16'hA5C3;
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
    end
    exp_cell_q.push_back(c);
  endtask

  task automatic strobe(input int c);
    @(posedge clk); #1;
    bus.i_dirty_set = '0;
    bus.i_dirty_set[c] = 1'b1;
    @(posedge clk); #1;
    bus.i_dirty_set = '0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int n = 0;
    while (byte_total < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(byte_total >= target), 64'd1);
  endtask

  int d0, b0;
  logic [N-1:0] two;

  initial begin
    bus.i_init_done = 1'b0;
    bus.i_dirty_set = '0;
    bus.i_full_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spi_en",   64'(bus.o_spi_en),    64'd0);
    chk("rst_spi_data", 64'(bus.o_spi_data),  64'd0);
    chk("rst_busy",     64'(bus.o_busy),      64'd0);
    chk("rst_done",     64'(bus.o_cell_done), 64'd0);
    chk("rst_cur",      64'(bus.o_cur_cell),  64'd0);
    chk("rst_raddr",    64'(bus.o_raddr),     64'd0);
    chk("rst_pending",  64'(bus.o_pending),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_init_done = 1'b1;

    // cell 0: fixed window 08..27 x 30..4F
    push_cell(0);
    strobe(0);
    wait_done(1, "cell0");
    chk("cell0_last_raddr", 64'(done_raddr), 64'h4F27);
    chk("cell0_pending",    64'(bus.o_pending), 64'd0);
    chk("cell0_drained",    64'(exp_q.size()), 64'd0);
    chk("cell0_bytes",      64'(byte_total), 64'd2059);

    // far corner cell
    push_cell(41);
    strobe(41);
    wait_done(2, "cell41");
    chk("cell41_last_raddr", 64'(done_raddr), 64'hEFE7);

    // two cells in one cycle: lowest index first
    d0 = done_cnt;
    push_cell(2);
    push_cell(5);
    two = '0; two[2] = 1'b1; two[5] = 1'b1;
    @(posedge clk); #1; bus.i_dirty_set = two;
    @(posedge clk); #1; bus.i_dirty_set = '0;
    wait_done(d0 + 2, "cells2_5");
    repeat (20) @(negedge clk);
    chk("cells2_5_count", 64'(done_cnt), 64'(d0 + 2));

    // re-strobe while drawing re-queues the cell
    d0 = done_cnt;
    b0 = byte_total;
    push_cell(3);
    strobe(3);
    wait_bytes(b0 + 1000, "cell3_mid");
    chk("cell3_busy_mid", 64'(bus.o_busy), 64'd1);
    push_cell(3);
    strobe(3);
    wait_done(d0 + 1, "cell3_first");
    chk("cell3_pend_after1", 64'(bus.o_pending[3]), 64'd1);
    wait_done(d0 + 2, "cell3_second");
    chk("cell3_pend_after2", 64'(bus.o_pending[3]), 64'd0);

    // slow sender for the first 60 bytes of a cell
    d0 = done_cnt;
    b0 = byte_total;
    busy_len = 50;
    push_cell(10);
    strobe(10);
    wait_bytes(b0 + 60, "slow");
    busy_len = 0;
    wait_done(d0 + 1, "cell10");
    chk("drained_pre_idle", 64'(exp_q.size()), 64'd0);

    // init low: queued cell must not start
    bus.i_init_done = 1'b0;
    b0 = byte_total;
    strobe(7);
    repeat (200) @(negedge clk);
    chk("noinit_bytes",   64'(byte_total), 64'(b0));
    chk("noinit_busy",    64'(bus.o_busy), 64'd0);
    chk("noinit_pending", 64'(bus.o_pending), 64'h80);
    @(posedge clk); #1; bus.i_full_req = 1'b1;
    @(posedge clk); #1; bus.i_full_req = 1'b0;
    @(negedge clk);
    chk("full_req_pending", 64'(bus.o_pending), {22'd0, {N{1'b1}}});
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_pending", 64'(bus.o_pending), 64'd0);

    // reset at pixel byte 100 of a cell
    bus.i_init_done = 1'b1;
    b0 = byte_total;
    push_cell(7);
    strobe(7);
    wait_bytes(b0 + 111, "cell7_part");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cell_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("midrst_spi_en",  64'(bus.o_spi_en),  64'd0);
    chk("midrst_busy",    64'(bus.o_busy),    64'd0);
    chk("midrst_pending", 64'(bus.o_pending), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // fresh cell after reset starts again from CASET
    d0 = done_cnt;
    push_cell(20);
    strobe(20);
    wait_done(d0 + 1, "cell20");
    repeat (10) @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    chk("final_done_cnt", 64'(done_cnt), 64'd8);
    chk("final_busy", 64'(bus.o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
